// File: rtl/irq_delay_pause.sv
// Per-channel programmable delay with pause indication and sticky interrupt.
// One shared prescaler produces the delay tick; each channel runs an IDLE/WAIT/IRQ sequencer.
module irq_delay_pause #(
    parameter int CH    = 4,
    parameter int DW    = 4,
    parameter int PRESC = 1000,
    parameter int AUTO  = 0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [CH*DW-1:0] delay_input,
    input  logic [CH-1:0]    trigger,
    input  logic [CH-1:0]    abort,
    input  logic [CH-1:0]    irq_ack,
    output logic [CH-1:0]    pause_out,
    output logic [CH-1:0]    irq,
    output logic             irq_any,
    output logic [CH-1:0]    missed
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        IRQ  = 2'd2
    } state_t;

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0] rst_sync_reg;
    logic       rst_n_int;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_reg[1];

    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;
    logic          tick;

    always_comb begin
        tick       = (presc_reg == PRESC_LAST);
        presc_next = tick ? '0 : presc_reg + PW'(1);
    end

    always_ff @(posedge clk_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t          state_reg, state_next;
            logic [DW-1:0]   cnt_reg, cnt_next;
            logic [DW-1:0]   lat_reg, lat_next;
            logic            missed_reg, missed_next;
            logic            pause_reg, irq_reg;
            logic [DW-1:0]   field;

            assign field = delay_input[gi*DW +: DW];

            always_comb begin
                state_next  = state_reg;
                cnt_next    = cnt_reg;
                lat_next    = lat_reg;
                missed_next = missed_reg;
                case (state_reg)
                    IDLE: begin
                        if (trigger[gi]) begin
                            lat_next = field;
                            if (field != '0) begin
                                state_next = WAIT;
                                cnt_next   = field;
                            end else begin
                                state_next = IRQ;
                            end
                        end
                    end
                    WAIT: begin
                        if (trigger[gi]) begin
                            missed_next = 1'b1;
                        end
                        // Abort outranks a tick that would have finished the count.
                        if (abort[gi]) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (tick) begin
                            cnt_next = cnt_reg - DW'(1);
                            if (cnt_reg == DW'(1)) begin
                                state_next = IRQ;
                            end
                        end
                    end
                    IRQ: begin
                        if (irq_ack[gi]) begin
                            missed_next = 1'b0;
                            if ((AUTO != 0) && (lat_reg != '0)) begin
                                state_next = WAIT;
                                cnt_next   = lat_reg;
                            end else begin
                                state_next = IDLE;
                            end
                        end else if (trigger[gi]) begin
                            missed_next = 1'b1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk_clk or negedge rst_n_int) begin
                if (!rst_n_int) begin
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    lat_reg    <= '0;
                    missed_reg <= 1'b0;
                    pause_reg  <= 1'b0;
                    irq_reg    <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    lat_reg    <= lat_next;
                    missed_reg <= missed_next;
                    pause_reg  <= (state_next == WAIT);
                    irq_reg    <= (state_next == IRQ);
                end
            end

            assign pause_out[gi] = pause_reg;
            assign irq[gi]       = irq_reg;
            assign missed[gi]    = missed_reg;
        end
    endgenerate

    logic irq_any_reg;

    always_ff @(posedge clk_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            irq_any_reg <= 1'b0;
        end else begin
            irq_any_reg <= |irq;
        end
    end

    assign irq_any = irq_any_reg;

endmodule

// File: tb/tb_irq_delay_pause.sv
// Directed bench for irq_delay_pause: one-shot and auto-rearm at PRESC=1, plus a PRESC=4 reset scenario.
module tb_irq_delay_pause;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    logic [15:0] a_delay = '0, b_delay = '0, c_delay = '0;
    logic [3:0]  a_trig = '0, a_abort = '0, a_ack = '0;
    logic [3:0]  b_trig = '0, b_abort = '0, b_ack = '0;
    logic [3:0]  c_trig = '0, c_abort = '0, c_ack = '0;
    logic [3:0]  a_pause, a_irq, a_missed;
    logic [3:0]  b_pause, b_irq, b_missed;
    logic [3:0]  c_pause, c_irq, c_missed;
    logic        a_any, b_any, c_any;

    irq_delay_pause #(.CH(4), .DW(4), .PRESC(1), .AUTO(0)) u_one (
        .clk_clk(clk), .reset_reset_n(reset_n), .delay_input(a_delay),
        .trigger(a_trig), .abort(a_abort), .irq_ack(a_ack),
        .pause_out(a_pause), .irq(a_irq), .irq_any(a_any), .missed(a_missed)
    );

    irq_delay_pause #(.CH(4), .DW(4), .PRESC(1), .AUTO(1)) u_auto (
        .clk_clk(clk), .reset_reset_n(reset_n), .delay_input(b_delay),
        .trigger(b_trig), .abort(b_abort), .irq_ack(b_ack),
        .pause_out(b_pause), .irq(b_irq), .irq_any(b_any), .missed(b_missed)
    );

    irq_delay_pause #(.CH(4), .DW(4), .PRESC(4), .AUTO(0)) u_p4 (
        .clk_clk(clk), .reset_reset_n(reset_n), .delay_input(c_delay),
        .trigger(c_trig), .abort(c_abort), .irq_ack(c_ack),
        .pause_out(c_pause), .irq(c_irq), .irq_any(c_any), .missed(c_missed)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%0h required=none", obs);
        end else begin
            e = sb_q.pop_front();
            $display("check %s observed=%0h expected=%0h", e.tag, obs, e.val);
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] seen;
        int         n;

        // Power-up reset
        #2 reset_n = 1'b0;
        step(3);
        push("rst_pause", 0);   pop_check(32'(a_pause));
        push("rst_irq", 0);     pop_check(32'(a_irq));
        push("rst_any", 0);     pop_check(32'(a_any));
        push("rst_missed", 0);  pop_check(32'(a_missed));
        reset_n = 1'b1;
        step(5);

        // ch0 delay 5, one-shot
        a_delay = 16'h0005; a_trig = 4'b0001;
        step(1);
        a_trig = '0;
        for (int i = 0; i < 5; i++) begin
            push("d5_pause_hi", 1); pop_check(32'(a_pause[0]));
            step(1);
        end
        push("d5_pause_lo", 0);  pop_check(32'(a_pause));
        push("d5_irq", 1);       pop_check(32'(a_irq));
        push("d5_any_lag", 0);   pop_check(32'(a_any));
        step(1);
        push("d5_any", 1);       pop_check(32'(a_any));
        a_ack = 4'b0001;
        step(1);
        a_ack = '0;
        push("d5_ack_irq", 0);   pop_check(32'(a_irq));
        step(1);
        push("d5_ack_any", 0);   pop_check(32'(a_any));

        // ch1 delay 0 goes straight to irq
        a_delay = 16'h0000; a_trig = 4'b0010;
        step(1);
        a_trig = '0;
        push("d0_irq", 4'b0010); pop_check(32'(a_irq));
        push("d0_pause", 0);     pop_check(32'(a_pause));
        a_ack = 4'b0010;
        step(1);
        a_ack = '0;
        push("d0_ack_irq", 0);   pop_check(32'(a_irq));

        // ch2 delay 7, aborted in the third WAIT cycle
        a_delay = 16'h0700; a_trig = 4'b0100;
        step(1);
        a_trig = '0;
        step(2);
        push("ab_pause_hi", 1);  pop_check(32'(a_pause[2]));
        a_abort = 4'b0100;
        step(1);
        a_abort = '0;
        push("ab_pause_lo", 0);  pop_check(32'(a_pause[2]));
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | a_irq;
            step(1);
        end
        push("ab_no_irq", 0);    pop_check(32'(seen));

        // ch0 delay 3, retrigger during WAIT, then ack and trigger together
        a_delay = 16'h0003; a_trig = 4'b0001;
        step(1);
        a_trig = '0;
        step(1);
        a_trig = 4'b0001;
        step(1);
        a_trig = '0;
        push("rt_missed", 4'b0001); pop_check(32'(a_missed));
        push("rt_pause", 1);        pop_check(32'(a_pause[0]));
        step(1);
        push("rt_irq", 4'b0001);    pop_check(32'(a_irq));
        step(3);
        push("rt_irq_hold", 4'b0001); pop_check(32'(a_irq));
        push("rt_no_restart", 0);     pop_check(32'(a_pause));
        a_ack = 4'b0001; a_trig = 4'b0001;
        step(1);
        a_ack = '0; a_trig = '0;
        push("rt_ack_irq", 0);      pop_check(32'(a_irq));
        push("rt_ack_missed", 0);   pop_check(32'(a_missed));
        push("rt_ack_pause", 0);    pop_check(32'(a_pause));
        step(1);
        push("rt_idle_pause", 0);   pop_check(32'(a_pause));

        // Auto-rearm, delay 2, three rounds
        b_delay = 16'h0002; b_trig = 4'b0001;
        step(1);
        b_trig = '0;
        step(2);
        push("au_first_irq", 1);    pop_check(32'(b_irq[0]));
        for (int r = 0; r < 3; r++) begin
            b_ack = 4'b0001;
            step(1);
            b_ack = '0;
            push("au_pause1", 1);   pop_check(32'(b_pause[0]));
            push("au_irq_lo", 0);   pop_check(32'(b_irq[0]));
            step(1);
            push("au_pause2", 1);   pop_check(32'(b_pause[0]));
            step(1);
            push("au_irq_hi", 1);   pop_check(32'(b_irq[0]));
            push("au_pause_lo", 0); pop_check(32'(b_pause[0]));
        end

        // PRESC=4: all channels together, reset mid-count
        c_delay = 16'hF321; c_trig = 4'hF;
        step(1);
        c_trig = '0;
        push("p4_pause_all", 4'hF); pop_check(32'(c_pause));
        n = 0;
        while (c_pause[0] === 1'b1 && n < 20) begin
            n++;
            step(1);
        end
        push("p4_d1_range", 1);     pop_check(32'((n >= 1) && (n <= 4)));
        push("p4_d1_irq", 1);       pop_check(32'(c_irq[0]));
        step(10);
        push("p4_mid_pause3", 1);   pop_check(32'(c_pause[3]));
        push("p4_mid_any", 1);      pop_check(32'(c_any));
        #2 reset_n = 1'b0;
        #1;
        push("p4_rst_pause", 0);    pop_check(32'(c_pause));
        push("p4_rst_irq", 0);      pop_check(32'(c_irq));
        push("p4_rst_any", 0);      pop_check(32'(c_any));
        push("p4_rst_auto_irq", 0); pop_check(32'(b_irq));
        step(2);
        #3 reset_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 100; i++) begin
            seen = seen | c_irq | c_pause;
            step(1);
        end
        push("p4_quiet", 0);        pop_check(32'(seen));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
